instr_mem_loader: RTL
=====================

Name: instr_mem_loader

Overview:
- Writer side of the instruction bus. Receives a little-endian byte stream over a valid/ready link, normally from the UART RX.
- Assembles 32-bit instruction words and writes them sequentially into instruction memory.
- Holds the core in reset until the load completes.
- Checks each word's opcode field against the opcode set the control unit decodes, and flags any unsupported encoding.

Parameters:
- ADDR_WIDTH, 6, word-address width; memory depth DEPTH = 2**ADDR_WIDTH words.
- BASE_ADDR, 32'h0040_0000, byte address of the first instruction word.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_i  input  1  one-cycle pulse; begins a load in IDLE or DONE, ignored otherwise.
- byte_i  input  8  incoming stream byte.
- byte_valid_i  input  1  byte_i valid.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- mem_we_o  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr_o  output  32  byte address of the write.
- mem_wdata_o  output  32  assembled instruction word.
- cpu_reset_n_o  output  1  core reset, active-low; low while loading.
- done_o  output  1  level; load completed successfully.
- len_err_o  output  1  sticky; header word count exceeded DEPTH.
- illegal_o  output  1  sticky; at least one word carried an unsupported opcode.
- word_cnt_o  output  ADDR_WIDTH+1  words written so far.

Behaviour:
- Reset values: state IDLE; byte_ready_o=0, mem_we_o=0, mem_addr_o=BASE_ADDR, mem_wdata_o=0, cpu_reset_n_o=0, done_o=0, len_err_o=0, illegal_o=0, word_cnt_o=0.
- Handshake: a byte is accepted on a rising edge when byte_valid_i && byte_ready_o. byte_ready_o is high in LEN0, LEN1 and WORDS, and low in IDLE, DONE and WRITE.
- FSM states: IDLE, LEN0, LEN1, WORDS, WRITE, DONE.
  - IDLE: on start_i go to LEN0, clear len_err_o, illegal_o and word_cnt_o, and drive cpu_reset_n_o=0.
  - LEN0: accept N[7:0], go to LEN1.
  - LEN1: accept N[15:8]. Then:
    - N==0 goes to DONE.
    - N>DEPTH sets len_err_o and goes to IDLE with no writes.
    - Otherwise go to WORDS with the byte index at 0.
  - WORDS: accepted bytes fill word[8*k+7:8*k] for k=0..3 (little-endian). On the 4th byte, latch mem_wdata_o and go to WRITE.
  - WRITE (1 cycle):
    - Drive mem_we_o=1 with mem_addr_o = BASE_ADDR + 4*word_cnt_o.
    - Increment word_cnt_o at the end of the cycle.
    - If word_cnt_o+1 == N go to DONE, else go to WORDS.
  - DONE: done_o=1 and cpu_reset_n_o=1. start_i goes to LEN0, clears done_o and all flags, and drives cpu_reset_n_o low on the next cycle.
- Write timing: mem_we_o rises exactly one cycle after the edge that accepted the 4th byte. Sustained throughput is 4 bytes per 5 cycles.
- Opcode check: in WRITE, if mem_wdata_o[6:0] is not in {7'h33, 7'h13, 7'h37, 7'h23, 7'h03, 7'h6F, 7'h63}, set illegal_o. The word is still written. The flag does not block DONE.
- Width rules:
  - N is 16 bits; the N>DEPTH comparison is done at 17 bits.
  - mem_addr_o is 32 bits; the 4*word_cnt_o term is zero-extended, and overflow past 32 bits cannot occur for legal ADDR_WIDTH (≤16).
- Boundary conditions:
  - start_i during LEN0, LEN1, WORDS or WRITE is ignored.
  - byte_valid_i while byte_ready_o=0 is not consumed; the source must hold the byte.
  - Asserting reset mid-load aborts immediately to the reset values. Partially assembled bytes are discarded, and cpu_reset_n_o stays low.
  - N==DEPTH is legal: the last write is at BASE_ADDR + 4*(DEPTH-1) and word_cnt_o reaches DEPTH.

Decomposition:
- Shared package risc_v_pkg: the opcode localparams (R_TYPE 7'h33, I_TYPE_LOGIC 7'h13, U_TYPE_LUI 7'h37, S_TYPE_SW 7'h23, I_MEM_TYPE_LW 7'h03, J_TYPE_JAL 7'h6F, B_TYPE 7'h63), shared with the control unit so the legal set stays in one place. Also the loader state encoding.
- One natural sub-module: byte_to_word_packer (byte index counter plus 32-bit shift/assemble register, with a word_ready pulse). The FSM and address counter stay in the top module.

Test Plan:
- Basic load: start_i, header 02 00, bytes 33 05 00 00 13 05 15 00 -> writes 32'h00000533 @ 32'h00400000 and 32'h00150513 @ 32'h00400004; done_o=1, cpu_reset_n_o=1, word_cnt_o=2, illegal_o=0.
- Zero length: header 00 00 -> no mem_we_o pulse; DONE two accepted bytes after start; cpu_reset_n_o=1.
- Over-length with ADDR_WIDTH=6: header 41 00 (N=65) -> len_err_o=1, state IDLE, no writes, cpu_reset_n_o=0.
- Illegal opcode: one word 7F 00 00 00 -> written @ BASE_ADDR, illegal_o=1, done_o=1.
- Backpressure and gaps: randomly deasserted byte_valid_i with 1-byte stalls, N=DEPTH=64 -> 64 in-order writes, last at 32'h004000FC, no lost or duplicated bytes, byte_ready_o low in every WRITE cycle.
- Reset mid-word: assert reset after 2 data bytes, then release and reload N=1 -> all outputs at reset values during reset; the reload writes only the new word at BASE_ADDR.

Source files
------------

// File: rtl/risc_v_pkg.sv
// Opcode set decoded by the control unit plus the loader FSM encoding.
// Keeping the legal opcodes here lets the loader and control unit agree by construction.
package risc_v_pkg;

  localparam logic [6:0] R_TYPE        = 7'h33;
  localparam logic [6:0] I_TYPE_LOGIC  = 7'h13;
  localparam logic [6:0] U_TYPE_LUI    = 7'h37;
  localparam logic [6:0] S_TYPE_SW     = 7'h23;
  localparam logic [6:0] I_MEM_TYPE_LW = 7'h03;
  localparam logic [6:0] J_TYPE_JAL    = 7'h6F;
  localparam logic [6:0] B_TYPE        = 7'h63;

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StWords,
    StWrite,
    StDone
  } loader_state_e;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    logic legal;
    case (op)
      R_TYPE, I_TYPE_LOGIC, U_TYPE_LUI, S_TYPE_SW,
      I_MEM_TYPE_LW, J_TYPE_JAL, B_TYPE: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input link and instruction-memory write port of the loader.
interface instr_mem_loader_if;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;

  modport slave (
    input  byte_i, byte_valid_i,
    output byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output byte_i, byte_valid_i,
    input  byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/instr_mem_loader_packer.sv
// Little-endian byte-to-word assembler; word_ready_o flags the accepted 4th byte.
module byte_to_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] buf_q, buf_d;

  always_comb begin
    idx_d = idx_q;
    buf_d = buf_q;
    if (clear_i) begin
      idx_d = '0;
      buf_d = '0;
    end else if (byte_en_i) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0:    buf_d[7:0]   = byte_i;
        2'd1:    buf_d[15:8]  = byte_i;
        2'd2:    buf_d[23:16] = byte_i;
        default: buf_d        = buf_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      buf_q <= '0;
    end else begin
      idx_q <= idx_d;
      buf_q <= buf_d;
    end
  end

  // Top byte comes straight from the link so the word is complete on the accepting edge.
  assign word_o       = {byte_i, buf_q};
  assign word_ready_o = byte_en_i && !clear_i && (idx_q == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory,
// holding the core in reset until the load completes.
module instr_mem_loader
  import risc_v_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter logic [31:0] BASE_ADDR  = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  instr_mem_loader_if.slave     bus,
  output logic                  cpu_reset_n_o,
  output logic                  done_o,
  output logic                  len_err_o,
  output logic                  illegal_o,
  output logic [ADDR_WIDTH:0]   word_cnt_o
);

  localparam logic [16:0] DepthW = 17'(2 ** ADDR_WIDTH);

  loader_state_e         state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  len_err_q, len_err_d;
  logic                  illegal_q, illegal_d;

  logic        ready;
  logic        accept;
  logic        start_ok;
  logic [15:0] n_full;
  logic [31:0] word;
  logic        word_ready;

  assign ready    = (state_q == StLen0) || (state_q == StLen1) || (state_q == StWords);
  assign accept   = bus.byte_valid_i && ready;
  assign start_ok = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign n_full   = {bus.byte_i, len_q[7:0]};

  byte_to_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (start_ok),
    .byte_en_i    (accept && (state_q == StWords)),
    .byte_i       (bus.byte_i),
    .word_o       (word),
    .word_ready_o (word_ready)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    len_err_d = len_err_q;
    illegal_d = illegal_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d   = StLen0;
          len_err_d = 1'b0;
          illegal_d = 1'b0;
          cnt_d     = '0;
        end
      end
      StLen0: begin
        if (accept) begin
          len_d[7:0] = bus.byte_i;
          state_d    = StLen1;
        end
      end
      StLen1: begin
        if (accept) begin
          len_d = n_full;
          if (n_full == 16'd0) begin
            state_d = StDone;
          end else if ({1'b0, n_full} > DepthW) begin
            len_err_d = 1'b1;
            state_d   = StIdle;
          end else begin
            state_d = StWords;
          end
        end
      end
      StWords: begin
        if (word_ready) begin
          wdata_d = word;
          state_d = StWrite;
        end
      end
      StWrite: begin
        cnt_d = cnt_q + 1'b1;
        if (!is_legal_opcode(wdata_q[6:0])) illegal_d = 1'b1;
        state_d = (17'(cnt_q) + 17'd1 == {1'b0, len_q}) ? StDone : StWords;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      len_q     <= '0;
      cnt_q     <= '0;
      wdata_q   <= '0;
      len_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      wdata_q   <= wdata_d;
      len_err_q <= len_err_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.byte_ready_o = ready;
  assign bus.mem_we_o     = (state_q == StWrite);
  assign bus.mem_addr_o   = BASE_ADDR + (32'(cnt_q) << 2);
  assign bus.mem_wdata_o  = wdata_q;
  assign cpu_reset_n_o    = (state_q == StDone);
  assign done_o           = (state_q == StDone);
  assign len_err_o        = len_err_q;
  assign illegal_o        = illegal_q;
  assign word_cnt_o       = cnt_q;

endmodule
